hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Stall/flush side of MIPS pipeline data-hazard handling; complements the EX/MEM->EX forwarding mux selects.
//  Detects hazards forwarding cannot cover: load-use, and branch-in-ID operand dependencies.
//  Drives PC/IF-ID hold, ID-EX bubble and IF-ID flush; freezes the whole pipe on I/D-cache miss.
// PARAMETERS
//  REG_AW      5   register address width
//  LD_BR_STALL 2   stall cycles for a branch in ID sourcing a load in EX (1..3)
//  CNT_W       32  perf counter width (HAZ_PERF_EN only)
// PORTS
//  clk          in  1       system clock, rising edge
//  rst_n        in  1       async active-low reset
//  id_rs        in  REG_AW  ID-stage rs
//  id_rt        in  REG_AW  ID-stage rt
//  id_uses_rt   in  1       ID instr reads rt (R-type, store, beq/bne)
//  id_is_branch in  1       ID instr is beq/bne/jr (resolved in ID)
//  ex_memread   in  1       ID/EX instr is a load
//  ex_regwrite  in  1       ID/EX instr writes a register
//  ex_rd        in  REG_AW  ID/EX destination (after RegDst mux)
//  branch_taken in  1       ID branch resolved taken this cycle
//  icache_stall in  1       I-cache miss in progress
//  dcache_stall in  1       D-cache miss in progress
//  pc_hold      out 1       PC keeps value
//  ifid_hold    out 1       IF/ID keeps value
//  idex_bubble  out 1       load NOP into ID/EX
//  ifid_flush   out 1       replace IF/ID with NOP
//  pipe_freeze  out 1       all pipeline regs hold (no bubble)
//  stall_cnt    out CNT_W   hazard-stall cycles (HAZ_PERF_EN)
//  freeze_cnt   out CNT_W   cache-freeze cycles (HAZ_PERF_EN)
// BEHAVIOUR
//  - match(r) = ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
//  - FSM states RUN, STALL, FREEZE; 2-bit remaining-stall counter rem; saved return state ret.
//  - rst_n low: state=RUN, rem=0, ret=RUN, counters=0; ALL outputs forced 0 (async, immediate).
//  - RUN, cache_stall=icache_stall|dcache_stall:
//    cache_stall -> pipe_freeze=1 same cycle, ret=RUN, next FREEZE; other outputs 0; hazard not evaluated.
//    else id_is_branch && ex_memread && match -> stall, rem=LD_BR_STALL-1.
//    else ex_memread && match -> load-use stall, rem=0.
//    else id_is_branch && ex_regwrite && match -> stall, rem=0.
//    stall cycle: pc_hold=ifid_hold=idex_bubble=1 same cycle (combinational); next STALL if rem!=0 else RUN.
//    no hazard && branch_taken -> ifid_flush=1 for that cycle only.
//  - STALL: pc_hold=ifid_hold=idex_bubble=1 regardless of hazard inputs; rem decrements per cycle; rem==0 -> RUN.
//    cache_stall in STALL: pipe_freeze=1, holds/bubble 0, rem frozen, ret=STALL, next FREEZE.
//  - FREEZE: pipe_freeze=1 only, while cache_stall=1. cache_stall falls -> next state=ret; in that cycle
//    outputs are computed as in state ret (RUN re-evaluates hazards/flush from held ID/EX contents).
//  - Priority: freeze > hazard stall > flush. Flush never asserted with any hold/bubble/freeze.
//  - Total stall for branch after load = LD_BR_STALL cycles; load-use and branch-after-ALU = 1 cycle.
//  - Outputs Mealy in RUN, Moore in STALL/FREEZE; no output registered. rst_n low mid-stall aborts to RUN.
// CONFIGURATION
//  HAZ_PERF_EN defined: stall_cnt +1 per cycle idex_bubble=1; freeze_cnt +1 per cycle pipe_freeze=1;
//   both saturate at all-ones, clear only on reset.
//  HAZ_PERF_EN undefined: stall_cnt/freeze_cnt ports and counter logic absent; control behaviour identical.
// TESTING
//  1 lw $8 in EX (ex_memread=1,ex_rd=8), add in ID id_rs=8 -> 1 cycle holds+bubble, then all 0.
//  2 lw $9 in EX, beq in ID id_rt=9,id_uses_rt=1, LD_BR_STALL=2 -> exactly 2 bubble cycles, then RUN.
//  3 add $5 in EX, beq id_rs=5 -> 1 stall; ex_rd=0 same case -> no stall; branch_taken, no hazard -> ifid_flush 1 cycle.
//  4 dcache_stall=1 for 4 cycles during 2nd cycle of case 2 -> pipe_freeze=1 x4, then 1 remaining bubble cycle.
//  5 rst_n low during STALL -> all outputs 0 immediately; after release RUN, counters 0 (HAZ_PERF_EN).
//  6 icache_stall=1 with branch_taken=1, no hazard -> ifid_flush=0 while frozen; flush asserted first cycle after.

Source files
------------

// File: rtl/hazard_stall_if.sv
// Hazard-unit bundle: ID/EX operand info, cache stalls, and stall/flush/freeze controls.
// Counter outputs exist only when HAZ_PERF_EN is defined.
interface hazard_stall_if #(
  parameter int unsigned REG_AW = 5
`ifdef HAZ_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_is_branch;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              icache_stall;
  logic              dcache_stall;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              pipe_freeze;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  freeze_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, ex_memread, ex_regwrite, ex_rd,
           branch_taken, icache_stall, dcache_stall,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze, stall_cnt, freeze_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, ex_memread, ex_regwrite, ex_rd,
           branch_taken, icache_stall, dcache_stall,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze, stall_cnt, freeze_cnt
  );
`else
  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, ex_memread, ex_regwrite, ex_rd,
           branch_taken, icache_stall, dcache_stall,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, ex_memread, ex_regwrite, ex_rd,
           branch_taken, icache_stall, dcache_stall,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze
  );
`endif
endinterface

// File: rtl/hazard_stall_ctrl.sv
// MIPS stall/flush control: load-use and branch-in-ID hazards, cache-miss freeze.
// Optional saturating stall/freeze perf counters under HAZ_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LD_BR_STALL = 2
`ifdef HAZ_PERF_EN
  , parameter int unsigned CNT_W     = 32
`endif
) (
  input logic         clk,
  input logic         rst_n,
  hazard_stall_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  localparam logic [REG_AW-1:0] ZERO_REG  = '0;
  localparam logic [1:0]        LD_BR_REM = 2'(LD_BR_STALL - 1);

  state_t     state, stateNext, ret, retNext, effState;
  logic [1:0] rem, remNext;
  logic       cacheStall, match, ldBrHaz, singleHaz;
  logic       stallC, flushC, freezeC;

  assign cacheStall = bus.icache_stall | bus.dcache_stall;
  assign match      = (bus.ex_rd != ZERO_REG) &&
                      ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
  assign ldBrHaz    = bus.id_is_branch && bus.ex_memread && match;
  assign singleHaz  = match && (bus.ex_memread || (bus.id_is_branch && bus.ex_regwrite));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ret   <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= stateNext;
      ret   <= retNext;
      rem   <= remNext;
    end
  end

  // Leaving FREEZE behaves exactly like the saved state in that same cycle.
  always_comb begin
    stateNext = state;
    retNext   = ret;
    remNext   = rem;
    stallC    = 1'b0;
    flushC    = 1'b0;
    freezeC   = 1'b0;
    effState  = (state == FREEZE) ? ret : state;
    if (cacheStall) begin
      freezeC   = 1'b1;
      stateNext = FREEZE;
      if (state != FREEZE) retNext = (state == STALL) ? STALL : RUN;
    end else begin
      case (effState)
        STALL: begin
          stallC    = 1'b1;
          remNext   = (rem != 2'd0) ? rem - 2'd1 : 2'd0;
          stateNext = (rem > 2'd1) ? STALL : RUN;
        end
        default: begin
          stateNext = RUN;
          if (ldBrHaz) begin
            stallC    = 1'b1;
            remNext   = LD_BR_REM;
            stateNext = (LD_BR_REM != 2'd0) ? STALL : RUN;
          end else if (singleHaz) begin
            stallC  = 1'b1;
            remNext = 2'd0;
          end else if (bus.branch_taken) begin
            flushC = 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are combinational and forced low while reset is held.
  assign bus.pc_hold     = rst_n & stallC;
  assign bus.ifid_hold   = rst_n & stallC;
  assign bus.idex_bubble = rst_n & stallC;
  assign bus.ifid_flush  = rst_n & flushC;
  assign bus.pipe_freeze = rst_n & freezeC;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stallCnt, freezeCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt  <= '0;
      freezeCnt <= '0;
    end else begin
      if (stallC && (stallCnt != '1))   stallCnt  <= stallCnt + CNT_W'(1);
      if (freezeC && (freezeCnt != '1)) freezeCnt <= freezeCnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt  = stallCnt;
  assign bus.freeze_cnt = freezeCnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Random + directed bench for hazard_stall_ctrl against an owed-bubble-count model.
module tb_hazard_stall_ctrl;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned LD_BR  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_if #(.REG_AW(REG_AW)) bus ();
  hazard_stall_ctrl #(.REG_AW(REG_AW), .LD_BR_STALL(LD_BR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int owed = 0;
  int owedNext = 0;
  logic expBubble = 1'b0, expFreeze = 1'b0;
`ifdef HAZ_PERF_EN
  longint unsigned sCnt = 0, fCnt = 0;
`endif

  function automatic logic [4:0] act();
    return {bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.ifid_flush, bus.pipe_freeze};
  endfunction

  // Model: bubbles still owed to an in-progress stall; a cache miss freezes everything.
  always @(negedge clk) begin
    logic [4:0] exp;
    logic m;
    exp = 5'b00000;
    if (!rst_n) begin
      owedNext = 0;
    end else begin
      m = (bus.ex_rd != 0) && (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
      owedNext = owed;
      if (bus.icache_stall || bus.dcache_stall) exp = 5'b00001;
      else if (owed > 0) begin exp = 5'b11100; owedNext = owed - 1; end
      else if (bus.id_is_branch && bus.ex_memread && m) begin exp = 5'b11100; owedNext = LD_BR - 1; end
      else if (m && (bus.ex_memread || (bus.id_is_branch && bus.ex_regwrite))) exp = 5'b11100;
      else if (bus.branch_taken) exp = 5'b00010;
    end
    expBubble = exp[2];
    expFreeze = exp[0];
    checks++;
    if (act() !== exp) begin
      failures++;
      $display("FAIL model t=%0t outputs got=%b want=%b", $time, act(), exp);
    end
`ifdef HAZ_PERF_EN
    checks++;
    if (bus.stall_cnt !== 32'(sCnt) || bus.freeze_cnt !== 32'(fCnt)) begin
      failures++;
      $display("FAIL counters t=%0t got=%0d/%0d want=%0d/%0d", $time, bus.stall_cnt, bus.freeze_cnt, sCnt, fCnt);
    end
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed <= 0;
`ifdef HAZ_PERF_EN
      sCnt <= 0;
      fCnt <= 0;
`endif
    end else begin
      owed <= owedNext;
`ifdef HAZ_PERF_EN
      if (expBubble && sCnt != 64'hFFFF_FFFF) sCnt <= sCnt + 1;
      if (expFreeze && fCnt != 64'hFFFF_FFFF) fCnt <= fCnt + 1;
`endif
    end
  end

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt, input logic br,
                       input logic memRd, input logic regWr, input logic [4:0] rd, input logic taken,
                       input logic ic, input logic dc);
    bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = usesRt; bus.id_is_branch = br;
    bus.ex_memread = memRd; bus.ex_regwrite = regWr; bus.ex_rd = rd; bus.branch_taken = taken;
    bus.icache_stall = ic; bus.dcache_stall = dc;
  endtask

  task automatic clr();
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Literal check in the middle of the cycle, then advance to just after the next edge.
  task automatic cyc(input logic [4:0] exp, input string nm);
    @(negedge clk);
    #1;
    checks++;
    if (act() !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act(), exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(5'b00000, "reset_idle");

    // load-use
    setIn(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "ldUse_stall");
    setIn(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'b00000, "ldUse_done");

    // branch after load: LD_BR cycles
    setIn(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "ldBr_stall1");
    setIn(5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "ldBr_stall2");
    cyc(5'b00000, "ldBr_done");

    // branch after ALU, rd=0, taken flush
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "brAlu_stall");
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'b00000, "brAlu_done");
    setIn(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(5'b00000, "rd0_noStall");
    setIn(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc(5'b00010, "taken_flush");
    clr();
    cyc(5'b00000, "flush_once");

    // dcache freeze during second ldBr stall cycle
    setIn(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "frz_stall1");
    setIn(5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(5'b00001, "frz_freeze");
    bus.dcache_stall = 1'b0;
    cyc(5'b11100, "frz_resume");
    cyc(5'b00000, "frz_done");

    // reset mid-stall
    setIn(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc(5'b11100, "rst_stall1");
    rst_n = 1'b0;
    #1;
    checks++;
    if (act() !== 5'b00000) begin
      failures++;
      $display("FAIL rst_async got=%b want=00000", act());
    end
    clr();
    @(posedge clk);
    #3 rst_n = 1'b1;
`ifdef HAZ_PERF_EN
    checks++;
    if (bus.stall_cnt !== 32'd0 || bus.freeze_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_counters got=%0d/%0d want=0/0", bus.stall_cnt, bus.freeze_cnt);
    end
`endif
    cyc(5'b00000, "rst_run");

    // icache freeze masks flush until released
    setIn(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    cyc(5'b00001, "ic_frz1");
    cyc(5'b00001, "ic_frz2");
    bus.icache_stall = 1'b0;
    cyc(5'b00010, "ic_flush");
    clr();
    cyc(5'b00000, "ic_done");

    // randomized traffic, small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      setIn(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
